// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input FIFO feeding a start/data/parity/stop
// serialiser with a registered, glitch-free TXD line.
module uart_tx_param #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_50M,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          baud_tick
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0]    FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 line_bit;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 push;
  logic                 pop;
  logic                 stop_done;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~(^w) : (^w);
  endfunction

  assign tx_ready  = (fifo_count != FIFO_FULL);
  assign push      = tx_valid && tx_ready;
  assign fifo_head = mem[rd_ptr];
  assign baud_tick = (state != IDLE) && (baud_cnt == CNT_LAST);
  assign stop_done = (state == STOP) && baud_tick && (bit_cnt == STOP_LAST);
  // Pop from IDLE, or on the last stop-bit edge so the next frame starts with no gap.
  assign pop       = (fifo_count != '0) && ((state == IDLE) || stop_done);
  assign busy      = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Word and its parity are captured at pop so later FIFO traffic cannot disturb the frame.
  always_ff @(posedge clk_50M) begin
    if (pop) begin
      shreg   <= fifo_head;
      par_bit <= calc_parity(fifo_head);
    end else if ((state == DATA) && baud_tick) begin
      shreg   <= shreg >> 1;
    end
  end

  always_comb begin
    line_bit = 1'b1;
    case (state)
      IDLE:    line_bit = 1'b1;
      START:   line_bit = 1'b0;
      DATA:    line_bit = shreg[0];
      PAR:     line_bit = par_bit;
      STOP:    line_bit = 1'b1;
      default: line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      uart_txd <= 1'b1;
    end else begin
      uart_txd <= line_bit;

      if ((state == IDLE) || baud_tick) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (baud_tick) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PAR: begin
          if (baud_tick) begin
            state   <= STOP;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= pop ? START : IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: several parameterisations, each frame sampled every
// clock and compared against hand-written bit patterns.
module tb_uart_tx_param;

  logic clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  logic rst_n, rst3_n;

  logic       v0, rdy0, txd0, busy0, tick0; logic [7:0] d0; logic [2:0] cnt0;
  logic       v1, rdy1, txd1, busy1, tick1; logic [6:0] d1; logic [2:0] cnt1;
  logic       v2, rdy2, txd2, busy2, tick2; logic [6:0] d2; logic [2:0] cnt2;
  logic       v3, rdy3, txd3, busy3, tick3; logic [7:0] d3; logic [2:0] cnt3;
  logic       v4, rdy4, txd4, busy4, tick4; logic [7:0] d4; logic [2:0] cnt4;
  logic       v5, rdy5, txd5, busy5, tick5; logic [8:0] d5; logic [2:0] cnt5;

  uart_tx_param u0 (.clk_50M(clk_50M), .rst_n(rst_n), .tx_valid(v0), .tx_data(d0), .tx_ready(rdy0),
                    .uart_txd(txd0), .busy(busy0), .fifo_count(cnt0), .baud_tick(tick0));
  uart_tx_param #(.BAUD(5000000), .DATA_BITS(7), .PARITY(2)) u1 (
    .clk_50M(clk_50M), .rst_n(rst_n), .tx_valid(v1), .tx_data(d1), .tx_ready(rdy1),
    .uart_txd(txd1), .busy(busy1), .fifo_count(cnt1), .baud_tick(tick1));
  uart_tx_param #(.BAUD(5000000), .DATA_BITS(7), .PARITY(1)) u2 (
    .clk_50M(clk_50M), .rst_n(rst_n), .tx_valid(v2), .tx_data(d2), .tx_ready(rdy2),
    .uart_txd(txd2), .busy(busy2), .fifo_count(cnt2), .baud_tick(tick2));
  uart_tx_param #(.BAUD(5000000)) u3 (
    .clk_50M(clk_50M), .rst_n(rst3_n), .tx_valid(v3), .tx_data(d3), .tx_ready(rdy3),
    .uart_txd(txd3), .busy(busy3), .fifo_count(cnt3), .baud_tick(tick3));
  uart_tx_param #(.BAUD(5000000), .STOP_BITS(2)) u4 (
    .clk_50M(clk_50M), .rst_n(rst_n), .tx_valid(v4), .tx_data(d4), .tx_ready(rdy4),
    .uart_txd(txd4), .busy(busy4), .fifo_count(cnt4), .baud_tick(tick4));
  uart_tx_param #(.BAUD(5000000), .DATA_BITS(9), .PARITY(2)) u5 (
    .clk_50M(clk_50M), .rst_n(rst_n), .tx_valid(v5), .tx_data(d5), .tx_ready(rdy5),
    .uart_txd(txd5), .busy(busy5), .fifo_count(cnt5), .baud_tick(tick5));

  int   sel = 0;
  logic line;
  always_comb begin
    line = 1'b1;
    case (sel)
      0: line = txd0;
      1: line = txd1;
      2: line = txd2;
      3: line = txd3;
      4: line = txd4;
      5: line = txd5;
      default: line = 1'b1;
    endcase
  end

  int   b0_fall = 0;
  logic b0_prev = 1'b0;
  int   tick1_cnt = 0;
  always @(negedge clk_50M) begin
    if (b0_prev && !busy0) b0_fall <= cyc;
    b0_prev <= busy0;
    if (tick1) tick1_cnt <= tick1_cnt + 1;
  end

  logic [7:0] b2b_words [6];

  // Waits (bounded) for a start bit on the selected line, then samples every clock of
  // nbits bit periods; got[i] is the first sample of bit i, glitch counts deviations.
  task automatic capture(input int div, input int nbits, input int limit,
                         output logic [15:0] got, output int glitch,
                         output int waited, output int t0);
    got = '1; glitch = 0; waited = 0; t0 = 0;
    while (line !== 1'b0 && waited < limit) begin
      @(negedge clk_50M);
      waited++;
    end
    if (line === 1'b0) begin
      t0 = cyc;
      for (int i = 0; i < nbits; i++)
        for (int c = 0; c < div; c++) begin
          if (c == 0) got[i] = line;
          else if (line !== got[i]) glitch++;
          @(negedge clk_50M);
        end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst3_n = 1'b0;
    v0 = 0; v1 = 0; v2 = 0; v3 = 0; v4 = 0; v5 = 0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0; d5 = '0;
    repeat (3) @(negedge clk_50M);
    tests++; if (txd0 !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b expected 1", txd0); end
    tests++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", rdy0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    tests++; if (cnt0 !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", cnt0); end
    tests++; if (tick0 !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b expected 0", tick0); end
    rst_n = 1'b1; rst3_n = 1'b1;
    repeat (2) @(negedge clk_50M);
    tests++;
    if ({txd1, txd2, txd3, txd4, txd5, rdy1, rdy2, rdy3, rdy4, rdy5} !== 10'h3FF) begin
      fails++; $display("FAIL idle_line_ready: got %b expected 1111111111",
                        {txd1, txd2, txd3, txd4, txd5, rdy1, rdy2, rdy3, rdy4, rdy5});
    end
    tests++;
    if ({busy1, busy2, busy3, busy4, busy5, tick1, tick2, tick3, tick4, tick5} !== 10'h000) begin
      fails++; $display("FAIL idle_busy_tick: got %b expected 0000000000",
                        {busy1, busy2, busy3, busy4, busy5, tick1, tick2, tick3, tick4, tick5});
    end
    tests++;
    if ({cnt1, cnt2, cnt3, cnt4, cnt5} !== 15'd0) begin
      fails++; $display("FAIL idle_counts: got %h expected 0", {cnt1, cnt2, cnt3, cnt4, cnt5});
    end
  endtask

  task automatic test_default_frame();
    logic [15:0] got; int gl, wt, t0, e_cyc;
    sel = 0;
    d0 = 8'h55; v0 = 1'b1;
    @(posedge clk_50M); #1; e_cyc = cyc; v0 = 1'b0;
    @(negedge clk_50M);
    tests++; if (cnt0 !== 3'd1) begin fails++; $display("FAIL def_count_after_push: got %0d expected 1", cnt0); end
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL def_busy_after_push: got %b expected 1", busy0); end
    @(negedge clk_50M);
    tests++; if (cnt0 !== 3'd0) begin fails++; $display("FAIL def_count_after_pop: got %0d expected 0", cnt0); end
    tests++; if (txd0 !== 1'b1) begin fails++; $display("FAIL def_line_before_start: got %b expected 1", txd0); end
    capture(5208, 10, 10, got, gl, wt, t0);
    tests++; if (wt !== 1) begin fails++; $display("FAIL def_start_latency: got %0d expected 1", wt); end
    tests++; if (got[9:0] !== {1'b1, 8'h55, 1'b0}) begin fails++; $display("FAIL def_frame_bits: got %b expected %b", got[9:0], {1'b1, 8'h55, 1'b0}); end
    tests++; if (gl !== 0) begin fails++; $display("FAIL def_frame_glitch: got %0d expected 0", gl); end
    tests++; if (b0_fall - e_cyc !== 52081) begin fails++; $display("FAIL def_busy_fall: got %0d expected 52081", b0_fall - e_cyc); end
    tests++; if ({txd0, busy0, cnt0} !== 5'b10000) begin fails++; $display("FAIL def_after_frame: got %b expected 10000", {txd0, busy0, cnt0}); end
  endtask

  task automatic test_parity();
    logic [15:0] got; int gl, wt, t0, tk;
    sel = 1; tk = tick1_cnt;
    d1 = 7'h07; v1 = 1'b1;
    @(posedge clk_50M); #1; v1 = 1'b0;
    capture(10, 10, 20, got, gl, wt, t0);
    tests++; if (got[9:0] !== {1'b1, 1'b1, 7'h07, 1'b0}) begin fails++; $display("FAIL even_parity_frame: got %b expected %b", got[9:0], {1'b1, 1'b1, 7'h07, 1'b0}); end
    tests++; if (gl !== 0) begin fails++; $display("FAIL even_parity_glitch: got %0d expected 0", gl); end
    tests++; if (tick1_cnt - tk !== 10) begin fails++; $display("FAIL baud_tick_count: got %0d expected 10", tick1_cnt - tk); end
    sel = 2;
    d2 = 7'h07; v2 = 1'b1;
    @(posedge clk_50M); #1; v2 = 1'b0;
    capture(10, 10, 20, got, gl, wt, t0);
    tests++; if (got[9:0] !== {1'b1, 1'b0, 7'h07, 1'b0}) begin fails++; $display("FAIL odd_parity_frame: got %b expected %b", got[9:0], {1'b1, 1'b0, 7'h07, 1'b0}); end
    tests++; if (gl !== 0) begin fails++; $display("FAIL odd_parity_glitch: got %0d expected 0", gl); end
  endtask

  task automatic test_back_to_back();
    sel = 3;
    b2b_words[0] = 8'hA5; b2b_words[1] = 8'h3C; b2b_words[2] = 8'hF0;
    b2b_words[3] = 8'h0F; b2b_words[4] = 8'h81; b2b_words[5] = 8'h7E;
    fork
      begin
        int acc0, n;
        acc0 = 0;
        for (int w = 0; w < 6; w++) begin
          n = 0;
          v3 = 1'b1; d3 = b2b_words[w];
          while (!rdy3 && n < 500) begin
            d3 = 8'hFF ^ 8'(n);
            @(posedge clk_50M); #1; n++;
          end
          d3 = b2b_words[w];
          @(posedge clk_50M); #1;
          if (w == 0) acc0 = cyc;
          if (w == 4) begin
            tests++; if (cnt3 !== 3'd4) begin fails++; $display("FAIL b2b_full_count: got %0d expected 4", cnt3); end
            tests++; if (rdy3 !== 1'b0) begin fails++; $display("FAIL b2b_ready_low: got %b expected 0", rdy3); end
          end
          if (w == 5) begin
            tests++; if (cyc - acc0 !== 102) begin fails++; $display("FAIL b2b_stall_release: got %0d expected 102", cyc - acc0); end
          end
        end
        v3 = 1'b0;
      end
      begin
        logic [15:0] got; int gl, wt, t0;
        for (int f = 0; f < 6; f++) begin
          capture(10, 10, 300, got, gl, wt, t0);
          tests++; if (got[9:0] !== {1'b1, b2b_words[f], 1'b0}) begin fails++; $display("FAIL b2b_frame%0d: got %b expected %b", f, got[9:0], {1'b1, b2b_words[f], 1'b0}); end
          tests++; if (gl !== 0) begin fails++; $display("FAIL b2b_glitch%0d: got %0d expected 0", f, gl); end
          if (f > 0) begin
            tests++; if (wt !== 0) begin fails++; $display("FAIL b2b_gap%0d: got %0d expected 0", f, wt); end
          end
        end
      end
    join
    tests++; if ({busy3, cnt3} !== 4'b0000) begin fails++; $display("FAIL b2b_drained: got %b expected 0000", {busy3, cnt3}); end
  endtask

  task automatic test_two_stop();
    logic [15:0] got; int gl, wt, t0a, t0b;
    sel = 4;
    v4 = 1'b1; d4 = 8'hC3;
    @(posedge clk_50M); #1; d4 = 8'h5A;
    @(posedge clk_50M); #1; v4 = 1'b0;
    capture(10, 11, 20, got, gl, wt, t0a);
    tests++; if (got[10:0] !== {2'b11, 8'hC3, 1'b0}) begin fails++; $display("FAIL stop2_frame0: got %b expected %b", got[10:0], {2'b11, 8'hC3, 1'b0}); end
    tests++; if (gl !== 0) begin fails++; $display("FAIL stop2_glitch0: got %0d expected 0", gl); end
    capture(10, 11, 20, got, gl, wt, t0b);
    tests++; if (wt !== 0) begin fails++; $display("FAIL stop2_gap: got %0d expected 0", wt); end
    tests++; if (got[10:0] !== {2'b11, 8'h5A, 1'b0}) begin fails++; $display("FAIL stop2_frame1: got %b expected %b", got[10:0], {2'b11, 8'h5A, 1'b0}); end
    tests++; if (gl !== 0) begin fails++; $display("FAIL stop2_glitch1: got %0d expected 0", gl); end
    tests++; if (cyc - t0a !== 220) begin fails++; $display("FAIL stop2_total_clocks: got %0d expected 220", cyc - t0a); end
    tests++; if ({txd4, busy4} !== 2'b10) begin fails++; $display("FAIL stop2_idle_after: got %b expected 10", {txd4, busy4}); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] got; int gl, wt, t0, n, lows;
    sel = 3;
    v3 = 1'b1; d3 = 8'h11;
    @(posedge clk_50M); #1; d3 = 8'h22;
    @(posedge clk_50M); #1; d3 = 8'h33;
    @(posedge clk_50M); #1; v3 = 1'b0;
    n = 0;
    while (txd3 !== 1'b0 && n < 20) begin @(negedge clk_50M); n++; end
    repeat (45) @(negedge clk_50M);
    tests++; if (cnt3 !== 3'd2) begin fails++; $display("FAIL rst_mid_queued: got %0d expected 2", cnt3); end
    #2; rst3_n = 1'b0; #1;
    tests++; if (txd3 !== 1'b1) begin fails++; $display("FAIL rst_mid_line: got %b expected 1", txd3); end
    tests++; if (busy3 !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy3); end
    tests++; if (cnt3 !== 3'd0) begin fails++; $display("FAIL rst_mid_count: got %0d expected 0", cnt3); end
    repeat (3) @(negedge clk_50M);
    rst3_n = 1'b1;
    @(negedge clk_50M);
    d3 = 8'hA3; v3 = 1'b1;
    @(posedge clk_50M); #1; v3 = 1'b0;
    capture(10, 10, 20, got, gl, wt, t0);
    tests++; if (got[9:0] !== {1'b1, 8'hA3, 1'b0}) begin fails++; $display("FAIL rst_after_frame: got %b expected %b", got[9:0], {1'b1, 8'hA3, 1'b0}); end
    tests++; if (gl !== 0) begin fails++; $display("FAIL rst_after_glitch: got %0d expected 0", gl); end
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (txd3 !== 1'b1) lows++;
      @(negedge clk_50M);
    end
    tests++; if (lows !== 0) begin fails++; $display("FAIL rst_no_residue: got %0d low clocks expected 0", lows); end
    tests++; if ({busy3, cnt3} !== 4'b0000) begin fails++; $display("FAIL rst_after_idle: got %b expected 0000", {busy3, cnt3}); end
  endtask

  task automatic test_nine_bits();
    logic [15:0] got; int gl, wt, t0;
    sel = 5;
    d5 = 9'h1A5; v5 = 1'b1;
    @(posedge clk_50M); #1; v5 = 1'b0;
    capture(10, 12, 20, got, gl, wt, t0);
    tests++; if (got[11:0] !== {1'b1, 1'b1, 9'h1A5, 1'b0}) begin fails++; $display("FAIL nine_bit_frame: got %b expected %b", got[11:0], {1'b1, 1'b1, 9'h1A5, 1'b0}); end
    tests++; if (gl !== 0) begin fails++; $display("FAIL nine_bit_glitch: got %0d expected 0", gl); end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_parity();
    test_back_to_back();
    test_two_stop();
    test_reset_midframe();
    test_nine_bits();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
